// File: rtl/id_ex_ctrl_pipe.sv
// ID-stage control decode, load-use hazard detection and ID/EX control register.
// Bubbles are inserted on flush, stall, invalid or illegal instructions.
package id_ex_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_FN  = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;

    typedef struct packed {
        logic       regWrite;
        logic [2:0] aluOp;
        logic       aluSrc;
        logic       regDst;
        logic       branch;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

module id_ex_ctrl_pipe
    import id_ex_ctrl_pkg::*;
#(
    parameter int OP_W      = 6,
    parameter int REG_W     = 5,
    parameter int ALUOP_W   = 3,
    parameter bit HAZARD_EN = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               id_valid_i,
    input  logic [31:0]        id_instr_i,
    input  logic               flush_i,
    output logic               stall_o,
    output logic               ex_valid_o,
    output logic               ex_reg_write_o,
    output logic [ALUOP_W-1:0] ex_alu_op_o,
    output logic               ex_alu_src_o,
    output logic               ex_reg_dst_o,
    output logic               ex_branch_o,
    output logic               ex_mem_read_o,
    output logic               ex_mem_write_o,
    output logic               ex_mem_to_reg_o,
    output logic [REG_W-1:0]   ex_rs_o,
    output logic [REG_W-1:0]   ex_rt_o,
    output logic [REG_W-1:0]   ex_rd_o,
    output logic               illegal_o,
    output logic [CNT_W-1:0]   stall_cnt_o,
    output logic [CNT_W-1:0]   flush_cnt_o
);

    logic [OP_W-1:0]  opcode;
    logic [REG_W-1:0] idRs;
    logic [REG_W-1:0] idRt;
    logic [REG_W-1:0] idRd;
    logic             unusedImm;

    assign opcode    = id_instr_i[31 -: OP_W];
    assign idRs      = id_instr_i[25 -: REG_W];
    assign idRt      = id_instr_i[20 -: REG_W];
    assign idRd      = id_instr_i[15 -: REG_W];
    assign unusedImm = ^id_instr_i[15-REG_W:0];

    logic isR;
    logic isBeq;
    logic isAddi;
    logic isSlti;
    logic isLw;
    logic isSw;

    assign isR    = (opcode == OP_W'(OP_RTYPE));
    assign isBeq  = (opcode == OP_W'(OP_BEQ));
    assign isAddi = (opcode == OP_W'(OP_ADDI));
    assign isSlti = (opcode == OP_W'(OP_SLTI));
    assign isLw   = (opcode == OP_W'(OP_LW));
    assign isSw   = (opcode == OP_W'(OP_SW));

    ctrl_t decCtrl;
    logic  decIllegal;

    always_comb begin
        decCtrl    = CTRL_NOP;
        decIllegal = 1'b0;
        unique case (1'b1)
            isR: begin
                decCtrl.regWrite = 1'b1;
                decCtrl.aluOp    = ALU_FN;
                decCtrl.regDst   = 1'b1;
            end
            isAddi: begin
                decCtrl.regWrite = 1'b1;
                decCtrl.aluOp    = ALU_ADD;
                decCtrl.aluSrc   = 1'b1;
            end
            isSlti: begin
                decCtrl.regWrite = 1'b1;
                decCtrl.aluOp    = ALU_SLT;
                decCtrl.aluSrc   = 1'b1;
            end
            isBeq: begin
                decCtrl.aluOp    = ALU_SUB;
                decCtrl.branch   = 1'b1;
            end
            isLw: begin
                decCtrl.regWrite = 1'b1;
                decCtrl.aluOp    = ALU_ADD;
                decCtrl.aluSrc   = 1'b1;
                decCtrl.memRead  = 1'b1;
                decCtrl.memToReg = 1'b1;
            end
            isSw: begin
                decCtrl.aluOp    = ALU_ADD;
                decCtrl.aluSrc   = 1'b1;
                decCtrl.memWrite = 1'b1;
            end
            default: begin
                decIllegal = 1'b1;
            end
        endcase
    end

    ctrl_t            exCtrl;
    logic             exValid;
    logic [REG_W-1:0] exRs;
    logic [REG_W-1:0] exRt;
    logic [REG_W-1:0] exRd;
    logic             illegalQ;
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;

    // Register x0 is hardwired zero, so a load into it never creates a dependency.
    logic rtIsSrc;
    logic rsMatch;
    logic rtMatch;
    logic hazard;

    assign rtIsSrc = isR | isBeq | isSw;
    assign rsMatch = (exRt == idRs);
    assign rtMatch = rtIsSrc & (exRt == idRt);
    assign hazard  = HAZARD_EN & id_valid_i & exValid & exCtrl.memRead
                   & (exRt != '0) & (rsMatch | rtMatch);

    assign stall_o = hazard & ~flush_i;

    logic             loadEn;
    logic             nxtIllegal;

    always_comb begin
        loadEn     = 1'b0;
        nxtIllegal = 1'b0;
        if (flush_i) begin
            loadEn     = 1'b0;
        end else if (stall_o) begin
            loadEn     = 1'b0;
        end else if (!id_valid_i) begin
            loadEn     = 1'b0;
        end else if (decIllegal) begin
            nxtIllegal = 1'b1;
        end else begin
            loadEn     = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            exCtrl   <= CTRL_NOP;
            exValid  <= 1'b0;
            exRs     <= '0;
            exRt     <= '0;
            exRd     <= '0;
            illegalQ <= 1'b0;
        end else begin
            illegalQ <= nxtIllegal;
            if (loadEn) begin
                exCtrl  <= decCtrl;
                exValid <= 1'b1;
                exRs    <= idRs;
                exRt    <= idRt;
                exRd    <= idRd;
            end else begin
                exCtrl  <= CTRL_NOP;
                exValid <= 1'b0;
                exRs    <= '0;
                exRt    <= '0;
                exRd    <= '0;
            end
        end
    end

    // Event counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (stall_o && stallCnt != '1) begin
                stallCnt <= stallCnt + CNT_W'(1);
            end
            if (flush_i && flushCnt != '1) begin
                flushCnt <= flushCnt + CNT_W'(1);
            end
        end
    end

    assign ex_valid_o      = exValid;
    assign ex_reg_write_o  = exCtrl.regWrite;
    assign ex_alu_op_o     = ALUOP_W'(exCtrl.aluOp);
    assign ex_alu_src_o    = exCtrl.aluSrc;
    assign ex_reg_dst_o    = exCtrl.regDst;
    assign ex_branch_o     = exCtrl.branch;
    assign ex_mem_read_o   = exCtrl.memRead;
    assign ex_mem_write_o  = exCtrl.memWrite;
    assign ex_mem_to_reg_o = exCtrl.memToReg;
    assign ex_rs_o         = exRs;
    assign ex_rt_o         = exRt;
    assign ex_rd_o         = exRd;
    assign illegal_o       = illegalQ;
    assign stall_cnt_o     = stallCnt;
    assign flush_cnt_o     = flushCnt;

endmodule
